// File: rtl/otter_crypto_pkg.sv
// Shared types and ISA constants for the OTTER crypto sequencer.
// ENCRY opcode/funct3 values and the register-file write-select code used by the CU decoder.
package otter_crypto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } crypto_state_t;

  localparam logic [6:0] ENCRY_OP      = 7'b0011100;
  localparam logic [2:0] F3_ENC        = 3'b010;
  localparam logic [2:0] F3_DEC        = 3'b011;
  localparam logic [2:0] CRYPTO_WR_SEL = 3'd4;

endpackage

// File: rtl/otter_crypto_rnd_cnt.sv
// Loadable up/down round counter: presets to 0 (enc) or ROUNDS-1 (dec), flags the last round.
// Steps once per step pulse; never advances past the last round, so the index never wraps.
module otter_crypto_rnd_cnt #(
  parameter int ROUNDS = 16,
  parameter int RW     = $clog2(ROUNDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic          step,
  output logic [RW-1:0] idx,
  output logic          last
);

  localparam logic [RW-1:0] IDX_MAX = RW'(ROUNDS - 1);

  always_comb begin
    last = dec ? (idx == '0) : (idx == IDX_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= dec ? IDX_MAX : '0;
    end else if (step && !last) begin
      idx <= dec ? idx - 1'b1 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/otter_crypto_ctrl.sv
// OTTER crypto sequencer: start -> LOAD -> ROUNDS acked rounds -> DONE writeback; stalls the CPU throughout.
// Optional CRYPTO_INT_ABORT_EN: an accepted interrupt in LOAD/RUN abandons the operation.
module otter_crypto_ctrl
  import otter_crypto_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 16,
  parameter int RW     = $clog2(ROUNDS) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              crypto_start,
  input  logic              crypto_sel,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_key,
  input  logic              int_taken,
  output logic              rnd_load,
  output logic              rnd_req,
  input  logic              rnd_ack,
  input  logic [DATA_W-1:0] rnd_state,
  output logic [RW-1:0]     rnd_idx,
  output logic              rnd_dec,
  output logic [DATA_W-1:0] rnd_data,
  output logic [DATA_W-1:0] rnd_key,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  crypto_state_t state, state_nxt;
  logic          rnd_hs;
  logic          rnd_last;
  logic          abort;

  assign rnd_hs = rnd_req && rnd_ack;

`ifdef CRYPTO_INT_ABORT_EN
  assign abort = int_taken && ((state == LOAD) || (state == RUN));
`else
  logic unused_int_taken;
  assign unused_int_taken = int_taken;
  assign abort = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (crypto_start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (rnd_hs && rnd_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    rnd_load     = 1'b0;
    rnd_req      = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: stall = crypto_start;
      LOAD: begin
        rnd_load = 1'b1;
        stall    = 1'b1;
      end
      RUN: begin
        rnd_req = 1'b1;
        stall   = 1'b1;
      end
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured only on an accepted start; a start held high later is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rnd_data <= '0;
      rnd_key  <= '0;
      rnd_dec  <= 1'b0;
    end else if ((state == IDLE) && crypto_start) begin
      rnd_data <= rs1_data;
      rnd_key  <= rs2_key;
      rnd_dec  <= crypto_sel;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result <= '0;
    end else if (rnd_hs) begin
      result <= rnd_state;
    end
  end

  otter_crypto_rnd_cnt #(
    .ROUNDS (ROUNDS),
    .RW     (RW)
  ) u_rnd_cnt (
    .clk  (CLK),
    .rst  (RST),
    .load (rnd_load),
    .dec  (rnd_dec),
    .step (rnd_hs),
    .idx  (rnd_idx),
    .last (rnd_last)
  );

endmodule

// File: tb/tb_otter_crypto_ctrl.sv
// Bench for otter_crypto_ctrl: behavioural round core, scoreboard of expected final blocks.
module tb_otter_crypto_ctrl;

  localparam int DATA_W = 32;
  parameter  int ROUNDS = 16;
  localparam int RW     = $clog2(ROUNDS) + 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              crypto_start, crypto_sel, int_taken;
  logic [DATA_W-1:0] rs1_data, rs2_key;
  logic              rnd_load, rnd_req, rnd_ack, rnd_dec;
  logic [DATA_W-1:0] rnd_state, rnd_data, rnd_key, result;
  logic [RW-1:0]     rnd_idx;
  logic              stall, busy, result_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] sb[$];
  bit ack_slow = 1'b0;
  int phase = 0;

  always #5 CLK = ~CLK;

  otter_crypto_ctrl #(.DATA_W(DATA_W), .ROUNDS(ROUNDS), .RW(RW)) dut (
    .CLK(CLK), .RST(RST), .crypto_start(crypto_start), .crypto_sel(crypto_sel),
    .rs1_data(rs1_data), .rs2_key(rs2_key), .int_taken(int_taken),
    .rnd_load(rnd_load), .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_state(rnd_state),
    .rnd_idx(rnd_idx), .rnd_dec(rnd_dec), .rnd_data(rnd_data), .rnd_key(rnd_key),
    .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
  );

  function automatic logic [31:0] round_f(input logic [31:0] d, input logic [31:0] k,
                                          input logic [RW-1:0] i);
    return (d ^ {k[15:0], k[31:16]}) + (32'(i) * 32'h9E37_79B9);
  endfunction

  // Round core model: acks every cycle, or on every 3rd cycle of a held request.
  always @(posedge CLK) begin
    if (rnd_req) phase <= (phase == 2) ? 0 : phase + 1;
    else         phase <= 0;
  end
  assign rnd_ack   = ack_slow ? (phase == 2) : 1'b1;
  assign rnd_state = round_f(rnd_data, rnd_key, rnd_idx);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_load"},  32'(rnd_load), 0);
    check({tag, "_req"},   32'(rnd_req), 0);
    check({tag, "_idx"},   32'(rnd_idx), 0);
    check({tag, "_dec"},   32'(rnd_dec), 0);
    check({tag, "_data"},  rnd_data, 0);
    check({tag, "_key"},   rnd_key, 0);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_rv"},    32'(result_valid), 0);
    check({tag, "_res"},   result, 0);
  endtask

  // abort_kind: 0 none, 1 reset, 2 interrupt; fired when round abort_at is being requested.
  task automatic run_op(input logic [31:0] d, input logic [31:0] k, input logic dec,
                        input bit slow, input bit hold, input int abort_kind, input int abort_at);
    int stall_cnt = 0, req_cnt = 0, rv_cnt = 0, post = 0;
    int per = slow ? 3 : 1;
    bit done = 0, fired = 0, aborted = 0;
    logic [RW-1:0] exp_idx, last_i;
    logic [31:0] exp_res = '0;
    exp_idx = dec ? RW'(ROUNDS - 1) : '0;
    last_i  = dec ? '0 : RW'(ROUNDS - 1);
    @(negedge CLK);
    ack_slow = slow;
    crypto_start = 1'b1; crypto_sel = dec; rs1_data = d; rs2_key = k;
    sb.push_back(round_f(d, k, last_i));
    for (int cyc = 0; cyc < 400 && post < 4 && !aborted; cyc++) begin
      if (cyc > 0) begin
        @(negedge CLK);
        if (!hold || done) crypto_start = 1'b0;
        if (hold && !done) rs1_data = $urandom;
        int_taken = 1'b0;
      end
      #1;
      if (fired && abort_kind == 2) begin
`ifdef CRYPTO_INT_ABORT_EN
        check("int_busy", 32'(busy), 0);
        check("int_stall", 32'(stall), 0);
        check("int_rv", 32'(result_valid), 0);
        sb.delete();
        aborted = 1;
        break;
`endif
      end
      stall_cnt += int'(stall);
      req_cnt   += int'(rnd_req);
      if (rnd_load) check("load_data", rnd_data, d);
      if (rnd_req && rnd_ack) begin
        check("idx", 32'(rnd_idx), 32'(exp_idx));
        if (rnd_idx != last_i) exp_idx = dec ? exp_idx - 1'b1 : exp_idx + 1'b1;
      end
      if (rnd_req && !fired && abort_kind != 0 && int'(rnd_idx) == abort_at) begin
        fired = 1;
        if (abort_kind == 1) begin
          crypto_start = 1'b0;
          RST = 1'b1;
          #1;
          check_zero("rst_mid");
          sb.delete();
          @(posedge CLK);
          @(negedge CLK);
          check("rst_no_rv", 32'(result_valid), 0);
          RST = 1'b0;
          aborted = 1;
          break;
        end else begin
          int_taken = 1'b1;
        end
      end
      if (result_valid) begin
        rv_cnt++;
        if (!done) begin
          check("done_data", rnd_data, d);
          check("done_key", rnd_key, k);
          check("done_dec", 32'(rnd_dec), 32'(dec));
          if (sb.size() == 0) check("sb_empty", 1, 0);
          else begin
            exp_res = sb.pop_front();
            check("result", result, exp_res);
          end
        end
        done = 1;
      end
      if (done) post++;
    end
    if (!aborted) begin
      check("completed", 32'(done), 1);
      check("stall_cycles", 32'(stall_cnt), 32'(2 + ROUNDS * per));
      check("req_cycles", 32'(req_cnt), 32'(ROUNDS * per));
      check("rv_pulses", 32'(rv_cnt), 1);
      check("result_hold", result, exp_res);
    end
    ack_slow = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    crypto_start = 1'b0; crypto_sel = 1'b0; int_taken = 1'b0;
    rs1_data = '0; rs2_key = '0;
    #3;
    check_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    run_op(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b1, 1'b0, 0, 0);
    run_op(32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op(32'h2468_ACE0, 32'hFEDC_BA98, 1'b0, 1'b0, 1'b0, 1, (ROUNDS > 7) ? 7 : 0);
    check("rst_sb_clear", 32'(sb.size()), 0);
    run_op(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(32'h5555_AAAA, 32'h7777_8888, 1'b0, 1'b0, 1'b0, 2, (ROUNDS > 5) ? 5 : 0);
    run_op(32'h0BAD_CAFE, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
